register_file: RTL and testbench

- 32-entry x 64-bit integer register file for the RV64-style core datapath, in the decode/writeback stage.
- Two combinational read ports (rs1 to out1, rs2 to out2) and one synchronous write port (rd, rd_in, rd_we).
- Register x0 is hardwired to zero.
- The write port bypasses to both read ports, so writeback and decode can share a cycle.

---
 rtl/core_pkg.sv | 19 +
 rtl/regfile_read_port.sv | 39 +++
 rtl/register_file.sv | 70 +++++++
 tb/tb_register_file.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core datapath types and constants for the integer register file.
// Address and data typedefs are sized for the RV64 architectural state.
package core_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xlen_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // A write only lands when it is enabled and not aimed at the hardwired x0.
    function automatic logic write_lands(input logic we, input reg_addr_t addr);
        return we && (addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array select, optional write forwarding, x0 forced to zero.
// Forwarding is held off during reset so the port shows the array, which clears on that edge.
module regfile_read_port
    import core_pkg::*;
#(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int NREG   = core_pkg::NREG,
    parameter int AW     = core_pkg::AW,
    parameter int BYPASS = 1
) (
    input  logic                      rst_n,
    input  logic [AW-1:0]             rs,
    input  logic [NREG-1:0][XLEN-1:0] regs_view,
    input  logic [AW-1:0]             wr_addr,
    input  logic                      wr_en,
    input  logic [XLEN-1:0]           wr_data,
    output logic [XLEN-1:0]           data
);

    logic rs_is_zero;
    logic wr_is_zero;
    logic fwd_hit;

    assign rs_is_zero = (rs == AW'(REG_ZERO));
    assign wr_is_zero = (wr_addr == AW'(REG_ZERO));
    assign fwd_hit    = (BYPASS != 0) && rst_n && wr_en && !wr_is_zero && (wr_addr == rs);

    // The zero check wins last, so x0 reads zero regardless of forwarding.
    always_comb begin
        data = regs_view[rs];
        if (fwd_hit) begin
            data = wr_data;
        end
        if (rs_is_zero) begin
            data = '0;
        end
    end

endmodule

// File: rtl/register_file.sv
// 32 x 64-bit integer register file with two combinational read ports and one write port.
// Storage and the write path live here; each read port is an instance of regfile_read_port.
module register_file
    import core_pkg::*;
#(
    parameter int XLEN   = core_pkg::XLEN,
    parameter int NREG   = core_pkg::NREG,
    parameter int AW     = core_pkg::AW,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic            rd_we,
    input  logic [XLEN-1:0] rd_in,
    output logic [XLEN-1:0] out1,
    output logic [XLEN-1:0] out2
);

    if (AW != $clog2(NREG)) begin : g_bad_aw
        $error("register_file: AW must equal clog2(NREG)");
    end

    logic [NREG-1:0][XLEN-1:0] regs;
    logic                      wr_lands;

    assign wr_lands = rd_we && (rd != AW'(REG_ZERO));

    // Reset clears every entry and discards a coincident write; x0 is never written.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (wr_lands) begin
            regs[rd] <= rd_in;
        end
    end

    regfile_read_port #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_port1 (
        .rst_n     (rst_n),
        .rs        (rs1),
        .regs_view (regs),
        .wr_addr   (rd),
        .wr_en     (rd_we),
        .wr_data   (rd_in),
        .data      (out1)
    );

    regfile_read_port #(
        .XLEN   (XLEN),
        .NREG   (NREG),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_port2 (
        .rst_n     (rst_n),
        .rs        (rs2),
        .regs_view (regs),
        .wr_addr   (rd),
        .wr_en     (rd_we),
        .wr_data   (rd_in),
        .data      (out2)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic
// compared against an architectural array model with forwarding applied at read time.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rd_we;
    logic [63:0] rd_in;
    logic [63:0] out1;
    logic [63:0] out2;

    int compared;
    int mismatched;

    logic [63:0] model [32];

    register_file dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rd    (rd),
        .rs1   (rs1),
        .rs2   (rs2),
        .rd_we (rd_we),
        .rd_in (rd_in),
        .out1  (out1),
        .out2  (out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic r_n, input logic [4:0] a_rd, input logic we,
                                 input logic [63:0] din, input logic [4:0] a1, input logic [4:0] a2);
        rst_n = r_n;
        rd    = a_rd;
        rd_we = we;
        rd_in = din;
        rs1   = a1;
        rs2   = a2;
        #1;
    endtask

    // What an architectural read should return right now, given the current write-port inputs.
    function automatic logic [63:0] expRead(input logic [4:0] addr);
        if (addr == 5'd0) return 64'd0;
        if (rst_n && rd_we && rd != 5'd0 && rd == addr) return rd_in;
        return model[addr];
    endfunction

    task automatic checkReads(input string tag);
        checkOutput({tag, "_out1"}, out1, expRead(rs1));
        checkOutput({tag, "_out2"}, out2, expRead(rs2));
    endtask

    // Advance one rising edge and apply its effect to the model, then settle.
    task automatic clockEdge();
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = 64'd0;
        end else if (rd_we && rd != 5'd0) begin
            model[rd] = rd_in;
        end
        #1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        for (int i = 0; i < 32; i++) model[i] = 'x;

        applyStimulus(1'b0, 5'd0, 1'b0, 64'd0, 5'd0, 5'd0);
        clockEdge();
        clockEdge();
        applyStimulus(1'b1, 5'd0, 1'b0, 64'd0, 5'd1, 5'd31);
        checkOutput("init_x1", out1, 64'd0);
        checkOutput("init_x31", out2, 64'd0);

        applyStimulus(1'b1, 5'd5, 1'b1, 64'hDEAD_BEEF, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b1, 5'd0, 1'b0, 64'd0, 5'd5, 5'd31);
        checkOutput("pre_rst_x5", out1, 64'hDEAD_BEEF);
        applyStimulus(1'b0, 5'd0, 1'b0, 64'd0, 5'd5, 5'd31);
        clockEdge();
        applyStimulus(1'b1, 5'd0, 1'b0, 64'd0, 5'd5, 5'd31);
        checkOutput("rst_x5", out1, 64'd0);
        checkOutput("rst_x31", out2, 64'd0);

        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b1, 5'(i), 1'b1, 64'(i), 5'd0, 5'd0);
            clockEdge();
            applyStimulus(1'b1, 5'(i), 1'b0, 64'd99, 5'(i), 5'(i));
            checkOutput("sweep_out1", out1, 64'(i));
            checkOutput("sweep_out2", out2, 64'(i));
            clockEdge();
            checkOutput("sweep_hold", out1, 64'(i));
        end

        applyStimulus(1'b1, 5'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd0);
        checkOutput("x0_pre_out1", out1, 64'd0);
        checkOutput("x0_pre_out2", out2, 64'd0);
        clockEdge();
        checkOutput("x0_post_out1", out1, 64'd0);
        checkOutput("x0_post_out2", out2, 64'd0);

        applyStimulus(1'b1, 5'd7, 1'b1, 64'd3, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b1, 5'd7, 1'b1, 64'd42, 5'd7, 5'd7);
        checkOutput("byp_out1", out1, 64'd42);
        checkOutput("byp_out2", out2, 64'd42);
        clockEdge();
        applyStimulus(1'b1, 5'd7, 1'b0, 64'd0, 5'd7, 5'd7);
        checkOutput("byp_after_out1", out1, 64'd42);
        checkOutput("byp_after_out2", out2, 64'd42);

        applyStimulus(1'b0, 5'd9, 1'b1, 64'd5, 5'd9, 5'd0);
        checkOutput("rst_nofwd", out1, 64'd9);
        clockEdge();
        checkOutput("rst_edge", out1, 64'd0);
        applyStimulus(1'b1, 5'd9, 1'b0, 64'd5, 5'd9, 5'd0);
        checkOutput("rst_discard", out1, 64'd0);

        applyStimulus(1'b1, 5'd3, 1'b1, 64'h1111, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b1, 5'd4, 1'b1, 64'h2222, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b1, 5'd0, 1'b0, 64'd0, 5'd3, 5'd4);
        checkOutput("dual_out1", out1, 64'h1111);
        checkOutput("dual_out2", out2, 64'h2222);
        applyStimulus(1'b1, 5'd0, 1'b0, 64'd0, 5'd4, 5'd3);
        checkOutput("swap_out1", out1, 64'h2222);
        checkOutput("swap_out2", out2, 64'h1111);

        // Random traffic; reads often aim at rd to exercise forwarding, reset is rare.
        for (int n = 0; n < 400; n++) begin
            logic [4:0]  a_rd;
            logic [4:0]  a1;
            logic [4:0]  a2;
            logic [63:0] din;
            a_rd = 5'($urandom_range(0, 31));
            a1   = ($urandom_range(0, 3) == 0) ? a_rd : 5'($urandom_range(0, 31));
            a2   = ($urandom_range(0, 3) == 0) ? a_rd : 5'($urandom_range(0, 31));
            din  = {$urandom, $urandom};
            applyStimulus(($urandom_range(0, 24) != 0), a_rd, 1'($urandom_range(0, 1)), din, a1, a2);
            checkReads("rand_pre");
            clockEdge();
            checkReads("rand_post");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
